// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the CPU core.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// resolves branch conditions against NZCV and raises the single-cycle
// strobes that move PC, IR, regfile, flags and data memory. A memory
// request that never gets acknowledged faults the core into HALTED.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_halt,
    input  logic        id_en,
    input  logic        id_branch,
    input  logic [3:0]  id_branch_cond,
    input  logic        id_ldst,
    input  logic        id_snl,
    input  logic        id_set_flags,
    input  logic        id_to_pc,
    input  logic [3:0]  flags,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        flags_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        pc_src,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] HALTED    = 3'd5;

    // Counter value seen on the last permitted waiting cycle.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT - 1);

    // ARM condition evaluation; nzcv = {N,Z,C,V}.
    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'd0:    pass = z;
            4'd1:    pass = !z;
            4'd2:    pass = c;
            4'd3:    pass = !c;
            4'd4:    pass = n;
            4'd5:    pass = !n;
            4'd6:    pass = v;
            4'd7:    pass = !v;
            4'd8:    pass = c && !z;
            4'd9:    pass = !c || z;
            4'd10:   pass = (n == v);
            4'd11:   pass = (n != v);
            4'd12:   pass = !z && (n == v);
            4'd13:   pass = z || (n != v);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    logic [2:0]    stateCur_r;
    logic [2:0]    nextState_s;
    logic [TW-1:0] timeoutCnt_r;
    logic [31:0]   retiredCnt_r;
    logic          fault_r;
    logic          wbLoad_r;
    logic          retire_s;
    logic          timeout_s;
    logic          clearCnt_s;
    logic          incCnt_s;
    logic          setWbLoad_s;
    logic          clrWbLoad_s;

    assign state   = stateCur_r;
    assign retired = retiredCnt_r;
    assign fault   = fault_r;
    assign halted  = (stateCur_r == HALTED);

    // Next-state and strobe decode; reset forces every strobe low.
    always_comb begin
        nextState_s = stateCur_r;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        flags_we    = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_src      = 1'b0;
        retire_s    = 1'b0;
        timeout_s   = 1'b0;
        incCnt_s    = 1'b0;
        setWbLoad_s = 1'b0;
        clrWbLoad_s = 1'b0;
        if (rst) begin
            nextState_s = FETCH;
        end else begin
            case (stateCur_r)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we       = 1'b1;
                        nextState_s = DECODE;
                    end else if (timeoutCnt_r == TIMEOUT_LAST) begin
                        timeout_s   = 1'b1;
                        nextState_s = HALTED;
                    end else begin
                        incCnt_s = 1'b1;
                    end
                end
                DECODE: begin
                    if (id_halt) begin
                        retire_s    = 1'b1;
                        nextState_s = HALTED;
                    end else begin
                        nextState_s = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (!id_en) begin
                        pc_inc      = 1'b1;
                        retire_s    = 1'b1;
                        nextState_s = FETCH;
                    end else if (id_branch) begin
                        if (condPass(id_branch_cond, flags)) begin
                            pc_load = 1'b1;
                            pc_src  = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        retire_s    = 1'b1;
                        nextState_s = FETCH;
                    end else if (id_ldst) begin
                        nextState_s = MEMORY;
                    end else begin
                        flags_we    = id_set_flags;
                        clrWbLoad_s = 1'b1;
                        nextState_s = WRITEBACK;
                    end
                end
                MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = id_snl;
                    if (dmem_ack) begin
                        if (id_snl) begin
                            pc_inc      = 1'b1;
                            retire_s    = 1'b1;
                            nextState_s = FETCH;
                        end else begin
                            setWbLoad_s = 1'b1;
                            nextState_s = WRITEBACK;
                        end
                    end else if (timeoutCnt_r == TIMEOUT_LAST) begin
                        timeout_s   = 1'b1;
                        nextState_s = HALTED;
                    end else begin
                        incCnt_s = 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (wbLoad_r) begin
                        reg_we = 1'b1;
                        wb_sel = 1'b1;
                        pc_inc = 1'b1;
                    end else if (id_to_pc) begin
                        pc_load = 1'b1;
                        pc_src  = 1'b0;
                    end else begin
                        reg_we = 1'b1;
                        pc_inc = 1'b1;
                    end
                    retire_s    = 1'b1;
                    nextState_s = FETCH;
                end
                HALTED: begin
                    nextState_s = HALTED;
                end
                default: begin
                    nextState_s = FETCH;
                end
            endcase
        end
        // Waiting counter restarts whenever a request state is freshly entered.
        clearCnt_s = (nextState_s != stateCur_r) &&
                     ((nextState_s == FETCH) || (nextState_s == MEMORY));
    end

    // State, timeout counter, retire counter, sticky fault and writeback source.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateCur_r   <= FETCH;
            timeoutCnt_r <= '0;
            retiredCnt_r <= 32'd0;
            fault_r      <= 1'b0;
            wbLoad_r     <= 1'b0;
        end else begin
            stateCur_r <= nextState_s;
            if (clearCnt_s) begin
                timeoutCnt_r <= '0;
            end else if (incCnt_s) begin
                timeoutCnt_r <= timeoutCnt_r + TW'(1);
            end else begin
                timeoutCnt_r <= timeoutCnt_r;
            end
            if (retire_s) begin
                retiredCnt_r <= retiredCnt_r + 32'd1;
            end else begin
                retiredCnt_r <= retiredCnt_r;
            end
            if (timeout_s) begin
                fault_r <= 1'b1;
            end else begin
                fault_r <= fault_r;
            end
            if (setWbLoad_s) begin
                wbLoad_r <= 1'b1;
            end else if (clrWbLoad_s) begin
                wbLoad_r <= 1'b0;
            end else begin
                wbLoad_r <= wbLoad_r;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven bench for cpu_sequencer with a scoreboard queue of expected
// per-cycle outputs, plus a sweep of every branch condition over several
// flag patterns against an independent condition model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_halt, id_en, id_branch, id_ldst, id_snl, id_set_flags, id_to_pc;
    logic [3:0]  id_branch_cond;
    logic [3:0]  flags;
    logic        imem_ack, dmem_ack;
    logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, wb_sel, flags_we;
    logic        pc_inc, pc_load, pc_src, halted, fault;
    logic [2:0]  state;
    logic [31:0] retired;

    cpu_sequencer #(.MEM_TIMEOUT(4), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .id_halt(id_halt), .id_en(id_en), .id_branch(id_branch),
        .id_branch_cond(id_branch_cond), .id_ldst(id_ldst), .id_snl(id_snl),
        .id_set_flags(id_set_flags), .id_to_pc(id_to_pc), .flags(flags),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .wb_sel(wb_sel), .flags_we(flags_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_src(pc_src),
        .halted(halted), .fault(fault), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Decoder encodings: {halt,en,branch,ldst,snl,set_flags,to_pc,cond[3:0]}
    localparam logic [10:0] ALU_SF = 11'b0_1_0_0_0_1_0_1110;
    localparam logic [10:0] ALU_PC = 11'b0_1_0_0_0_0_1_1110;
    localparam logic [10:0] NOP    = 11'b0_0_0_0_0_0_0_1110;
    localparam logic [10:0] BEQ    = 11'b0_1_1_0_0_0_0_0000;
    localparam logic [10:0] BNV    = 11'b0_1_1_0_0_0_0_1111;
    localparam logic [10:0] LOAD   = 11'b0_1_0_1_0_0_0_1110;
    localparam logic [10:0] STORE  = 11'b0_1_0_1_1_0_0_1110;
    localparam logic [10:0] HALT   = 11'b1_1_0_0_0_0_0_1110;

    // Strobe bits: {imem_req,ir_we,dmem_req,dmem_we,reg_we,wb_sel,flags_we,pc_inc,pc_load,pc_src}
    localparam logic [9:0] IREQ  = 10'b1000000000;
    localparam logic [9:0] IRWE  = 10'b0100000000;
    localparam logic [9:0] DREQ  = 10'b0010000000;
    localparam logic [9:0] DWE   = 10'b0001000000;
    localparam logic [9:0] REGWE = 10'b0000100000;
    localparam logic [9:0] WBSEL = 10'b0000010000;
    localparam logic [9:0] FLWE  = 10'b0000001000;
    localparam logic [9:0] PCINC = 10'b0000000100;
    localparam logic [9:0] PCLD  = 10'b0000000010;
    localparam logic [9:0] PCSRC = 10'b0000000001;
    localparam logic [9:0] NONE  = 10'b0000000000;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5;

    typedef struct {
        string       name;
        logic        rst;
        logic [10:0] id;
        logic [3:0]  fl;
        logic        ia;
        logic        da;
        logic [9:0]  expS;
        logic [2:0]  expSt;
        logic        expH;
        logic        expF;
        logic [31:0] expR;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   nApplied = 0;
    int   nFail    = 0;

    task automatic add(input string n, input logic r, input logic [10:0] id, input logic [3:0] fl,
                       input logic ia, input logic da, input logic [9:0] s, input logic [2:0] st,
                       input logic h, input logic f, input logic [31:0] rr);
        vec_t v;
        v.name = n; v.rst = r; v.id = id; v.fl = fl; v.ia = ia; v.da = da;
        v.expS = s; v.expSt = st; v.expH = h; v.expF = f; v.expR = rr;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle.
    task automatic apply(input vec_t v);
        vec_t       e;
        logic [9:0] gotS;
        @(negedge clk);
        rst = v.rst;
        {id_halt, id_en, id_branch, id_ldst, id_snl, id_set_flags, id_to_pc, id_branch_cond} = v.id;
        flags    = v.fl;
        imem_ack = v.ia;
        dmem_ack = v.da;
        sbq.push_back(v);
        #2;
        e    = sbq.pop_front();
        gotS = {imem_req, ir_we, dmem_req, dmem_we, reg_we, wb_sel, flags_we, pc_inc, pc_load, pc_src};
        nApplied++;
        if (gotS !== e.expS || state !== e.expSt || halted !== e.expH ||
            fault !== e.expF || retired !== e.expR) begin
            nFail++;
            $display("FAIL %s: got strobes=%b state=%0d halted=%b fault=%b retired=%0d, want strobes=%b state=%0d halted=%b fault=%b retired=%0d",
                     e.name, gotS, state, halted, fault, retired,
                     e.expS, e.expSt, e.expH, e.expF, e.expR);
        end
    endtask

    // Independent ARM condition model: pairs of conditions differ by cond[0].
    function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0:    base = f[2];
            3'd1:    base = f[1];
            3'd2:    base = f[3];
            3'd3:    base = f[0];
            3'd4:    base = f[1] & ~f[2];
            3'd5:    base = ~(f[3] ^ f[0]);
            3'd6:    base = ~f[2] & ~(f[3] ^ f[0]);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    logic [3:0] flagSet [7] = '{4'b0000, 4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b1001, 4'b1100};

    initial begin
        vec_t        v;
        logic [31:0] r;
        logic [10:0] br;

        rst = 1'b1;
        {id_halt, id_en, id_branch, id_ldst, id_snl, id_set_flags, id_to_pc, id_branch_cond} = 11'd0;
        flags = 4'd0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);

        // ALU op with flag update, immediate acks; acks outside FETCH/MEMORY ignored
        add("rst",    1'b1, ALU_SF, 4'b0000, 1'b1, 1'b0, NONE,          SF, 1'b0, 1'b0, 32'd0);
        add("alu_f",  1'b0, ALU_SF, 4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd0);
        add("alu_d",  1'b0, ALU_SF, 4'b0000, 1'b1, 1'b1, NONE,          SD, 1'b0, 1'b0, 32'd0);
        add("alu_e",  1'b0, ALU_SF, 4'b0000, 1'b1, 1'b1, FLWE,          SE, 1'b0, 1'b0, 32'd0);
        add("alu_w",  1'b0, ALU_SF, 4'b0000, 1'b1, 1'b1, REGWE | PCINC, SW, 1'b0, 1'b0, 32'd0);
        // Branch EQ with Z=1 taken, Z=0 not taken; NV with all flags never taken
        add("beq_f",  1'b0, BEQ,    4'b0100, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd1);
        add("beq_d",  1'b0, BEQ,    4'b0100, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd1);
        add("beq_t",  1'b0, BEQ,    4'b0100, 1'b1, 1'b0, PCLD | PCSRC,  SE, 1'b0, 1'b0, 32'd1);
        add("bne_f",  1'b0, BEQ,    4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd2);
        add("bne_d",  1'b0, BEQ,    4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd2);
        add("beq_nt", 1'b0, BEQ,    4'b0000, 1'b1, 1'b0, PCINC,         SE, 1'b0, 1'b0, 32'd2);
        add("bnv_f",  1'b0, BNV,    4'b1111, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd3);
        add("bnv_d",  1'b0, BNV,    4'b1111, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd3);
        add("bnv_e",  1'b0, BNV,    4'b1111, 1'b1, 1'b0, PCINC,         SE, 1'b0, 1'b0, 32'd3);
        // Load with dmem_ack on the 4th MEMORY cycle (last cycle before timeout)
        add("ld_f",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd4);
        add("ld_d",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd4);
        add("ld_e",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, NONE,          SE, 1'b0, 1'b0, 32'd4);
        add("ld_m1",  1'b0, LOAD,   4'b0000, 1'b1, 1'b0, DREQ,          SM, 1'b0, 1'b0, 32'd4);
        add("ld_m2",  1'b0, LOAD,   4'b0000, 1'b1, 1'b0, DREQ,          SM, 1'b0, 1'b0, 32'd4);
        add("ld_m3",  1'b0, LOAD,   4'b0000, 1'b1, 1'b0, DREQ,          SM, 1'b0, 1'b0, 32'd4);
        add("ld_m4",  1'b0, LOAD,   4'b0000, 1'b0, 1'b1, DREQ,          SM, 1'b0, 1'b0, 32'd4);
        add("ld_w",   1'b0, LOAD,   4'b0000, 1'b0, 1'b0, REGWE | WBSEL | PCINC, SW, 1'b0, 1'b0, 32'd4);
        // Store retires from MEMORY on ack
        add("st_f",   1'b0, STORE,  4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd5);
        add("st_d",   1'b0, STORE,  4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd5);
        add("st_e",   1'b0, STORE,  4'b0000, 1'b1, 1'b0, NONE,          SE, 1'b0, 1'b0, 32'd5);
        add("st_m",   1'b0, STORE,  4'b0000, 1'b1, 1'b1, DREQ | DWE | PCINC, SM, 1'b0, 1'b0, 32'd5);
        // ALU result to PC
        add("pc_f",   1'b0, ALU_PC, 4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd6);
        add("pc_d",   1'b0, ALU_PC, 4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd6);
        add("pc_e",   1'b0, ALU_PC, 4'b0000, 1'b1, 1'b0, NONE,          SE, 1'b0, 1'b0, 32'd6);
        add("pc_w",   1'b0, ALU_PC, 4'b0000, 1'b1, 1'b0, PCLD,          SW, 1'b0, 1'b0, 32'd6);
        // NOP
        add("nop_f",  1'b0, NOP,    4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd7);
        add("nop_d",  1'b0, NOP,    4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd7);
        add("nop_e",  1'b0, NOP,    4'b0000, 1'b1, 1'b0, PCINC,         SE, 1'b0, 1'b0, 32'd7);
        // HALT after a delayed fetch; stays halted with acks toggling
        add("h_f0",   1'b0, HALT,   4'b0000, 1'b0, 1'b0, IREQ,          SF, 1'b0, 1'b0, 32'd8);
        add("h_f1",   1'b0, HALT,   4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd8);
        add("h_d",    1'b0, HALT,   4'b0000, 1'b1, 1'b1, NONE,          SD, 1'b0, 1'b0, 32'd8);
        add("h_1",    1'b0, HALT,   4'b0000, 1'b1, 1'b1, NONE,          SH, 1'b1, 1'b0, 32'd9);
        add("h_2",    1'b0, HALT,   4'b0000, 1'b0, 1'b0, NONE,          SH, 1'b1, 1'b0, 32'd9);
        add("h_3",    1'b0, ALU_SF, 4'b0000, 1'b1, 1'b1, NONE,          SH, 1'b1, 1'b0, 32'd9);
        add("h_rst",  1'b1, ALU_SF, 4'b0000, 1'b1, 1'b1, NONE,          SH, 1'b1, 1'b0, 32'd9);
        // Fetch timeout with MEM_TIMEOUT=4
        add("to_1",   1'b0, NOP,    4'b0000, 1'b0, 1'b0, IREQ,          SF, 1'b0, 1'b0, 32'd0);
        add("to_2",   1'b0, NOP,    4'b0000, 1'b0, 1'b0, IREQ,          SF, 1'b0, 1'b0, 32'd0);
        add("to_3",   1'b0, NOP,    4'b0000, 1'b0, 1'b0, IREQ,          SF, 1'b0, 1'b0, 32'd0);
        add("to_4",   1'b0, NOP,    4'b0000, 1'b0, 1'b0, IREQ,          SF, 1'b0, 1'b0, 32'd0);
        add("to_h1",  1'b0, NOP,    4'b0000, 1'b0, 1'b0, NONE,          SH, 1'b1, 1'b1, 32'd0);
        add("to_h2",  1'b0, NOP,    4'b0000, 1'b1, 1'b1, NONE,          SH, 1'b1, 1'b1, 32'd0);
        add("to_rst", 1'b1, NOP,    4'b0000, 1'b0, 1'b0, NONE,          SH, 1'b1, 1'b1, 32'd0);
        // Recovery, then reset mid-MEMORY
        add("rc_f",   1'b0, NOP,    4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd0);
        add("rc_d",   1'b0, NOP,    4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd0);
        add("rc_e",   1'b0, NOP,    4'b0000, 1'b1, 1'b0, PCINC,         SE, 1'b0, 1'b0, 32'd0);
        add("rm_f",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, IREQ | IRWE,   SF, 1'b0, 1'b0, 32'd1);
        add("rm_d",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, NONE,          SD, 1'b0, 1'b0, 32'd1);
        add("rm_e",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, NONE,          SE, 1'b0, 1'b0, 32'd1);
        add("rm_m",   1'b0, LOAD,   4'b0000, 1'b1, 1'b0, DREQ,          SM, 1'b0, 1'b0, 32'd1);
        add("rm_rst", 1'b1, LOAD,   4'b0000, 1'b1, 1'b0, NONE,          SM, 1'b0, 1'b0, 32'd1);
        add("rm_aft", 1'b0, LOAD,   4'b0000, 1'b0, 1'b1, IREQ,          SF, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Branch condition sweep: every code against several flag patterns
        r = 32'd0;
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 7; k++) begin
                br = {7'b0110000, 4'(c)};
                v.rst = 1'b0; v.id = br; v.fl = flagSet[k]; v.da = 1'b0; v.expH = 1'b0; v.expF = 1'b0;
                v.expR = r;
                v.name = $sformatf("cond%0d_fl%b_f", c, flagSet[k]);
                v.ia = 1'b1; v.expS = IREQ | IRWE; v.expSt = SF;
                apply(v);
                v.name = $sformatf("cond%0d_fl%b_d", c, flagSet[k]);
                v.expS = NONE; v.expSt = SD;
                apply(v);
                v.name = $sformatf("cond%0d_fl%b_e", c, flagSet[k]);
                v.expS = refCond(4'(c), flagSet[k]) ? (PCLD | PCSRC) : PCINC; v.expSt = SE;
                apply(v);
                r = r + 32'd1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
        $finish;
    end

endmodule
